// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// Requester count, default RAM geometry and requester index type.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;
    localparam int NREQ       = 2;

    typedef logic [$clog2(NREQ)-1:0] req_idx_t;

    function automatic req_idx_t other_req(req_idx_t i);
        return ~i;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single priority pointer bit.
// Grant is combinational; the pointer moves to the loser after a grant.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    req_idx_t ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (&req) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = other_req(req_idx_t'(0));
        end else if (gnt[1]) begin
            ptr_d = other_req(req_idx_t'(1));
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between two requesters.
// Read data returns one cycle after the read grant on a shared bus.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] a0,
    input  logic [ADDR_W-1:0] a1,
    input  logic [DATA_W-1:0] di0,
    input  logic [DATA_W-1:0] di1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rv_q, rv_d;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .gnt (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        if (gnt[0]) begin
            ram_we = we0;
            ram_a  = a0;
            ram_di = di0;
        end else if (gnt[1]) begin
            ram_we = we1;
            ram_a  = a1;
            ram_di = di1;
        end
    end

    // A read response is owed to whoever got a read grant this cycle.
    assign rv_d = gnt & {~we1, ~we0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q <= '0;
        end else begin
            rv_q <= rv_d;
        end
    end

    assign rvalid0 = rv_q[0];
    assign rvalid1 = rv_q[1];
    assign rdata   = (|rv_q) ? ram_do : '0;

endmodule
